// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor
// Counts clock cycles and NUM_EVT single-bit pipeline events (stall, flush,
// retire, ...) over a bounded run window. Counters either wrap or saturate
// on overflow. Each counter has a sticky overflow flag. freeze_i holds the
// window. An atomic snapshot copies every live counter into a shadow bank,
// and rd_sel_i reads the shadow bank.
//
// Handshake: snap_req_i is sampled on every rising edge. There is no ready.
// The shadow bank always takes the live values present before that edge.
// snap_valid_o is high for the cycle after each edge that sampled
// snap_req_i=1, so a held request gives a continuous valid.

module pipeline_perf_monitor #(
  parameter int NUM_EVT    = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 30,
  parameter int SAT_MODE   = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic               freeze_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               snap_req_i,
  output logic               snap_valid_o,
  input  logic [3:0]         rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic               run_o,
  output logic               done_o,
  output logic [NUM_EVT:0]   ovf_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);

  state_t           state;
  state_t           state_next;
  logic             count_en;
  logic             window_end;

  logic [CNT_W-1:0] evt_cnt [NUM_EVT];
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] cyc_inc;
  logic [NUM_EVT:0] ovf;

  logic [CNT_W-1:0] shadow_evt [NUM_EVT];
  logic [CNT_W-1:0] shadow_cyc;
  logic             snap_valid;

  // Value a counter takes after one increment. At all-ones it wraps to 0
  // or stays at all-ones, depending on SAT_MODE.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if (v == ALL_ONES) begin
      return (SAT_MODE != 0) ? ALL_ONES : '0;
    end
    return v + CNT_W'(1);
  endfunction

  assign cyc_inc    = bump(cyc_cnt);
  // The window closes on the edge where the counted cycle total reaches MAX_CYCLES.
  assign window_end = (MAX_CYCLES != 0) && (cyc_inc == MAX_C);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. clr_i overrides every transition. Freeze holds RUN,
  // even across a start_i drop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_i) state_next = RUN;
      end
      RUN: begin
        if (!freeze_i) begin
          if (!start_i)        state_next = IDLE;
          else if (window_end) state_next = DONE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    if (clr_i) state_next = IDLE;
  end

  // Output logic: counting strobe and status flags derived from state
  always_comb begin
    count_en = 1'b0;
    run_o    = 1'b0;
    done_o   = 1'b0;
    case (state)
      RUN: begin
        run_o    = 1'b1;
        count_en = start_i && !freeze_i && !clr_i;
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: begin
        count_en = 1'b0;
      end
    endcase
  end

  // Live counters and sticky overflow flags. clr_i zeroes them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_cnt <= '0;
      ovf     <= '0;
      for (int k = 0; k < NUM_EVT; k++) evt_cnt[k] <= '0;
    end else if (clr_i) begin
      cyc_cnt <= '0;
      ovf     <= '0;
      for (int k = 0; k < NUM_EVT; k++) evt_cnt[k] <= '0;
    end else if (count_en) begin
      cyc_cnt <= cyc_inc;
      if (cyc_cnt == ALL_ONES) ovf[NUM_EVT] <= 1'b1;
      for (int k = 0; k < NUM_EVT; k++) begin
        if (evt_i[k]) begin
          evt_cnt[k] <= bump(evt_cnt[k]);
          if (evt_cnt[k] == ALL_ONES) ovf[k] <= 1'b1;
        end
      end
    end
  end

  // Shadow bank capture. It takes pre-edge live values and ignores clr_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_valid <= 1'b0;
      shadow_cyc <= '0;
      for (int k = 0; k < NUM_EVT; k++) shadow_evt[k] <= '0;
    end else begin
      snap_valid <= snap_req_i;
      if (snap_req_i) begin
        shadow_cyc <= cyc_cnt;
        for (int k = 0; k < NUM_EVT; k++) shadow_evt[k] <= evt_cnt[k];
      end
    end
  end

  // Shadow read mux. Event counters come first, then the cycle counter.
  // Any other index reads 0.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (rd_sel_i == 4'(k)) rd_data_o = shadow_evt[k];
    end
    if (rd_sel_i == 4'(NUM_EVT)) rd_data_o = shadow_cyc;
  end

  assign cycle_o      = cyc_cnt;
  assign ovf_o        = ovf;
  assign snap_valid_o = snap_valid;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed bench for pipeline_perf_monitor. The main instance uses the
// default parameters. Two 4-bit, unlimited-window instances (wrap and
// saturate) share the same inputs and are checked in the overflow section.

module tb_pipeline_perf_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic       freeze = 1'b0;
  logic [3:0] evt = 4'b0000;
  logic       snap_req = 1'b0;
  logic [3:0] rd_sel = 4'd0;

  logic        snap_valid;
  logic [31:0] rd_data;
  logic [31:0] cycle;
  logic        run;
  logic        done;
  logic [4:0]  ovf;

  logic        w_snap_valid, s_snap_valid;
  logic [3:0]  w_rd_data, s_rd_data, w_cycle, s_cycle;
  logic        w_run, s_run, w_done, s_done;
  logic [4:0]  w_ovf, s_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock and reset
  always #5 clk = ~clk;

  pipeline_perf_monitor #(.NUM_EVT(4), .CNT_W(32), .MAX_CYCLES(30), .SAT_MODE(0)) u_main (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .freeze_i(freeze),
    .evt_i(evt), .snap_req_i(snap_req), .snap_valid_o(snap_valid),
    .rd_sel_i(rd_sel), .rd_data_o(rd_data), .cycle_o(cycle),
    .run_o(run), .done_o(done), .ovf_o(ovf)
  );

  pipeline_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .MAX_CYCLES(0), .SAT_MODE(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .freeze_i(freeze),
    .evt_i(evt), .snap_req_i(snap_req), .snap_valid_o(w_snap_valid),
    .rd_sel_i(rd_sel), .rd_data_o(w_rd_data), .cycle_o(w_cycle),
    .run_o(w_run), .done_o(w_done), .ovf_o(w_ovf)
  );

  pipeline_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .MAX_CYCLES(0), .SAT_MODE(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .freeze_i(freeze),
    .evt_i(evt), .snap_req_i(snap_req), .snap_valid_o(s_snap_valid),
    .rd_sel_i(rd_sel), .rd_data_o(s_rd_data), .cycle_o(s_cycle),
    .run_o(s_run), .done_o(s_done), .ovf_o(s_ovf)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic do_clr();
    clr   = 1'b1;
    start = 1'b0;
    step(1);
    clr   = 1'b0;
  endtask

  task automatic snap();
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
  endtask

  task automatic read_shadow(input logic [3:0] sel, input string tag, input logic [31:0] exp);
    rd_sel = sel;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    // Reset state
    step(1);
    do_reset();
    check("rst_cycle", cycle, 0);
    check("rst_run", {31'd0, run}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_ovf", {27'd0, ovf}, 0);
    check("rst_snap_valid", {31'd0, snap_valid}, 0);
    read_shadow(4'd4, "rst_shadow_cyc", 0);

    // Full window, evt0 every cycle
    start = 1'b1;
    evt   = 4'b0001;
    step(30);
    check("win_cycle_29", cycle, 29);
    check("win_done_early", {31'd0, done}, 0);
    check("win_run", {31'd0, run}, 1);
    step(1);
    check("win_cycle_30", cycle, 30);
    check("win_done", {31'd0, done}, 1);
    check("win_run_off", {31'd0, run}, 0);
    step(3);
    check("win_hold_cycle", cycle, 30);
    check("win_hold_done", {31'd0, done}, 1);
    snap();
    check("win_snap_valid", {31'd0, snap_valid}, 1);
    read_shadow(4'd0, "win_cnt0", 30);
    read_shadow(4'd1, "win_cnt1", 0);
    read_shadow(4'd3, "win_cnt3", 0);
    read_shadow(4'd4, "win_shadow_cyc", 30);
    step(1);
    check("win_snap_valid_drop", {31'd0, snap_valid}, 0);

    // Freeze mid-window, all events
    do_clr();
    check("clr_done", {31'd0, done}, 0);
    check("clr_cycle", cycle, 0);
    evt   = 4'b1111;
    start = 1'b1;
    step(1);
    step(10);
    check("frz_cycle_10", cycle, 10);
    freeze = 1'b1;
    step(5);
    check("frz_hold_cycle", cycle, 10);
    check("frz_run", {31'd0, run}, 1);
    freeze = 1'b0;
    step(19);
    check("frz_cycle_29", cycle, 29);
    check("frz_done_early", {31'd0, done}, 0);
    step(1);
    check("frz_done", {31'd0, done}, 1);
    snap();
    for (int k = 0; k < 4; k++) read_shadow(4'(k), "frz_cnt", 30);
    check("frz_ovf", {27'd0, ovf}, 0);

    // Overflow: 4-bit wrap vs saturate over 17 counted cycles
    do_reset();
    evt   = 4'b0001;
    start = 1'b1;
    step(1);
    step(17);
    check("wrap_cycle", {28'd0, w_cycle}, 1);
    check("sat_cycle", {28'd0, s_cycle}, 15);
    check("wrap_ovf", {27'd0, w_ovf}, 32'h11);
    check("sat_ovf", {27'd0, s_ovf}, 32'h11);
    start = 1'b0;
    step(1);
    snap();
    rd_sel = 4'd0;
    #1;
    check("wrap_cnt0", {28'd0, w_rd_data}, 1);
    check("sat_cnt0", {28'd0, s_rd_data}, 15);
    step(2);
    check("wrap_ovf_sticky", {31'd0, w_ovf[0]}, 1);
    check("sat_ovf_sticky", {31'd0, s_ovf[0]}, 1);
    do_clr();
    check("wrap_ovf_clr", {27'd0, w_ovf}, 0);
    check("sat_ovf_clr", {27'd0, s_ovf}, 0);

    // Snapshot at cycle 10, evt1 every cycle
    evt   = 4'b0010;
    start = 1'b1;
    step(1);
    step(10);
    check("snp_cycle_10", cycle, 10);
    snap();
    check("snp_valid", {31'd0, snap_valid}, 1);
    check("snp_live_cycle", cycle, 11);
    read_shadow(4'd4, "snp_shadow_cyc", 10);
    read_shadow(4'd1, "snp_cnt1", 10);
    read_shadow(4'd7, "snp_sel7", 0);
    read_shadow(4'd0, "snp_cnt0", 0);
    step(1);
    check("snp_valid_drop", {31'd0, snap_valid}, 0);
    check("snp_live_12", cycle, 12);
    snap_req = 1'b1;
    step(1);
    check("snp_hold_valid1", {31'd0, snap_valid}, 1);
    read_shadow(4'd4, "snp_hold_cyc1", 12);
    step(1);
    check("snp_hold_valid2", {31'd0, snap_valid}, 1);
    read_shadow(4'd4, "snp_hold_cyc2", 13);
    snap_req = 1'b0;
    step(1);
    check("snp_hold_drop", {31'd0, snap_valid}, 0);

    // Pause at cycle 12 for 3 cycles
    do_clr();
    evt   = 4'b0000;
    start = 1'b1;
    step(1);
    step(12);
    check("pse_cycle_12", cycle, 12);
    start = 1'b0;
    step(1);
    check("pse_run_off", {31'd0, run}, 0);
    step(2);
    check("pse_hold", cycle, 12);
    start = 1'b1;
    step(1);
    check("pse_reentry_run", {31'd0, run}, 1);
    check("pse_reentry_cycle", cycle, 12);
    step(17);
    check("pse_cycle_29", cycle, 29);
    check("pse_done_early", {31'd0, done}, 0);
    step(1);
    check("pse_done", {31'd0, done}, 1);
    check("pse_cycle_30", cycle, 30);

    // Asynchronous reset mid-clock during RUN
    do_clr();
    evt   = 4'b1111;
    start = 1'b1;
    step(1);
    step(5);
    check("ar_cycle_5", cycle, 5);
    snap_req = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("ar_cycle", cycle, 0);
    check("ar_run", {31'd0, run}, 0);
    check("ar_snap_valid", {31'd0, snap_valid}, 0);
    rd_sel = 4'd4;
    #1;
    check("ar_shadow", rd_data, 0);
    snap_req = 1'b0;
    rst = 1'b0;

    // clr together with snapshot
    step(1);
    step(7);
    check("cs_cycle_7", cycle, 7);
    clr      = 1'b1;
    snap_req = 1'b1;
    step(1);
    clr      = 1'b0;
    snap_req = 1'b0;
    check("cs_snap_valid", {31'd0, snap_valid}, 1);
    check("cs_live_cycle", cycle, 0);
    check("cs_run", {31'd0, run}, 0);
    read_shadow(4'd4, "cs_shadow_cyc", 7);
    read_shadow(4'd2, "cs_shadow_cnt2", 7);
    start = 1'b0;
    step(1);
    snap();
    read_shadow(4'd2, "cs_live_cnt2", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
